button_input_conditioner: RTL and testbench

Conditions the raw hall-call and car-call push-button lines before they reach the elevator controller. It synchronises each raw line, debounces press and release, and emits a single-cycle new-request pulse per accepted press. Pulses for buttons that are already lit are masked. It sits directly upstream of the elevator controller: its outputs drive that block's new-request inputs, and the controller's current-button outputs feed back into it.

---
 rtl/button_input_conditioner_if.sv | 27 ++
 rtl/button_input_conditioner.sv | 92 +++++++++
 tb/tb_button_input_conditioner.sv | 135 +++++++++++++
 3 files changed

// File: rtl/button_input_conditioner_if.sv
// button_input_conditioner_if: raw, lit and new-request button buses between the pads, the conditioner and the controller
// Ports (signals):
//   raw_*      12 hall + 9 car-1 + 9 car-2 unsynchronised push-button lines, 1 = pressed
//   current_*  lit buttons fed back from the controller
//   new_*      registered one-cycle press pulses toward the controller
// Modports: master drives raw/current and observes new; slave is the conditioner.
interface button_input_conditioner_if;
   logic [11:0] raw_floor_button;
   logic [9:1]  raw_internal_button1;
   logic [9:1]  raw_internal_button2;
   logic [11:0] current_real_floor_button;
   logic [9:1]  current_internal_button1;
   logic [9:1]  current_internal_button2;
   logic [11:0] new_real_floor_button;
   logic [9:1]  new_internal_button1;
   logic [9:1]  new_internal_button2;
   modport master (
      output raw_floor_button, raw_internal_button1, raw_internal_button2,
      output current_real_floor_button, current_internal_button1, current_internal_button2,
      input  new_real_floor_button, new_internal_button1, new_internal_button2
   );
   modport slave (
      input  raw_floor_button, raw_internal_button1, raw_internal_button2,
      input  current_real_floor_button, current_internal_button1, current_internal_button2,
      output new_real_floor_button, new_internal_button1, new_internal_button2
   );
endinterface

// File: rtl/button_input_conditioner.sv
// button_input_conditioner: synchronise, debounce and edge-detect 30 push-button lines into masked one-cycle request pulses
// Ports:
//   clk_i     rising-edge clock
//   reset_ni  asynchronous active-low reset
//   btn_if    slave side of button_input_conditioner_if (raw/current in, new out)
// Channels are packed as {car2[9:1], car1[9:1], hall[11:0]} = bits [29:21], [20:12], [11:0].
module button_input_conditioner #(
   parameter int DEBOUNCE_CLKS = 4,
   parameter int CNT_W = 16
) (
   input logic clk_i,
   input logic reset_ni,
   button_input_conditioner_if.slave btn_if
);
   localparam int N = 30;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CLKS);
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;
   if (DEBOUNCE_CLKS < 1 || DEBOUNCE_CLKS > 65535) begin : g_bad_debounce
      $error("DEBOUNCE_CLKS must lie in 1..65535");
   end
   if (CNT_W < 31 && (1 << CNT_W) <= DEBOUNCE_CLKS) begin : g_bad_cnt_w
      $error("CNT_W too narrow to hold DEBOUNCE_CLKS");
   end
   logic [N-1:0] raw, lit, s1_q, s2_q, fire, new_q;
   assign raw = {btn_if.raw_internal_button2, btn_if.raw_internal_button1, btn_if.raw_floor_button};
   assign lit = {btn_if.current_internal_button2, btn_if.current_internal_button1, btn_if.current_real_floor_button};
   assign btn_if.new_real_floor_button = new_q[11:0];
   assign btn_if.new_internal_button1  = new_q[20:12];
   assign btn_if.new_internal_button2  = new_q[29:21];
   // Lit state is sampled at the firing edge only; a masked press is consumed, not retried.
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) begin
         s1_q  <= '0;
         s2_q  <= '0;
         new_q <= '0;
      end else begin
         s1_q  <= raw;
         s2_q  <= s1_q;
         new_q <= fire & ~lit;
      end
   for (genvar c = 0; c < N; c++) begin : g_ch
      state_e st_q, st_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic fire_c;
      always_ff @(posedge clk_i or negedge reset_ni)
         if (!reset_ni) begin
            st_q  <= RELEASED;
            cnt_q <= '0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
         end
      always_comb begin
         st_d   = st_q;
         cnt_d  = cnt_q;
         fire_c = 1'b0;
         case (st_q)
            RELEASED: begin
               st_d  = s2_q[c] ? PRESS_WAIT : RELEASED;
               cnt_d = s2_q[c] ? CNT_W'(1) : '0;
            end
            PRESS_WAIT:
               if (!s2_q[c]) begin
                  st_d  = RELEASED;
                  cnt_d = '0;
               end else if (cnt_q == LIMIT) begin
                  st_d   = PRESSED;
                  cnt_d  = '0;
                  fire_c = 1'b1;
               end else cnt_d = cnt_q + 1'b1;
            PRESSED:
               if (!s2_q[c]) begin
                  st_d  = RELEASE_WAIT;
                  cnt_d = CNT_W'(1);
               end
            RELEASE_WAIT:
               if (s2_q[c]) begin
                  st_d  = PRESSED;
                  cnt_d = '0;
               end else if (cnt_q == LIMIT) begin
                  st_d  = RELEASED;
                  cnt_d = '0;
               end else cnt_d = cnt_q + 1'b1;
            default: begin
               st_d  = RELEASED;
               cnt_d = '0;
            end
         endcase
      end
      assign fire[c] = fire_c;
   end
endmodule

// File: tb/tb_button_input_conditioner.sv
// tb_button_input_conditioner: table-driven scoreboard bench for button_input_conditioner
module tb_button_input_conditioner;
   localparam int D = 4;
   typedef struct {
      logic [29:0] raw;
      logic [29:0] lit;
      logic [29:0] exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int errors = 0;
   vec_t tbl[$];
   vec_t sb[$];
   button_input_conditioner_if bus();
   button_input_conditioner #(.DEBOUNCE_CLKS(D), .CNT_W(16)) dut (
      .clk_i(clk),
      .reset_ni(rst_n),
      .btn_if(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout required completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end
   function automatic logic [29:0] fb(input int i);
      return 30'(1) << i;
   endfunction
   function automatic logic [29:0] c1(input int i);
      return 30'(1) << (11 + i);
   endfunction
   function automatic logic [29:0] c2(input int i);
      return 30'(1) << (20 + i);
   endfunction
   function automatic logic [29:0] outs();
      return {bus.new_internal_button2, bus.new_internal_button1, bus.new_real_floor_button};
   endfunction
   task automatic drive(input logic [29:0] raw, input logic [29:0] lit);
      bus.raw_floor_button          = raw[11:0];
      bus.raw_internal_button1      = raw[20:12];
      bus.raw_internal_button2      = raw[29:21];
      bus.current_real_floor_button = lit[11:0];
      bus.current_internal_button1  = lit[20:12];
      bus.current_internal_button2  = lit[29:21];
   endtask
   task automatic check(input string tag, input logic [29:0] exp);
      logic [29:0] got;
      got = outs();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: new=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic add(input logic [29:0] raw, input logic [29:0] lit, input int n,
                      input int pulse_row, input logic [29:0] pulse);
      for (int r = 0; r < n; r++) tbl.push_back('{raw, lit, (r == pulse_row) ? pulse : 30'd0});
   endtask
   task automatic run_tbl(input string name);
      vec_t e;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].raw, tbl[i].lit);
         sb.push_back(tbl[i]);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s[%0d]: scoreboard empty, got 0 entries required 1", name, i);
         end else begin
            e = sb.pop_front();
            check($sformatf("%s[%0d]", name, i), e.exp);
         end
      end
      tbl.delete();
   endtask
   initial begin
      rst_n = 1'b0;
      drive('0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", '0);
      rst_n = 1'b1;
      add(fb(3), '0, 12, D + 2, fb(3));
      add('0, '0, 10, -1, '0);
      run_tbl("clean_press");
      add(c1(5), '0, D, -1, '0);
      add('0, '0, 10, -1, '0);
      run_tbl("glitch");
      add(c1(7), '0, D + 1, -1, '0);
      add('0, '0, 10, D + 2 - (D + 1), c1(7));
      run_tbl("min_width");
      add(c2(2), c2(2), 10, -1, '0);
      add('0, c2(2), 8, -1, '0);
      add(c2(2), '0, 10, D + 2, c2(2));
      add('0, '0, 10, -1, '0);
      run_tbl("lit_mask");
      add(fb(5), fb(4) | c1(5), 10, D + 2, fb(5));
      add('0, '0, 10, -1, '0);
      run_tbl("lit_other");
      add(fb(0), '0, 8, D + 2, fb(0));
      for (int i = 0; i < 20; i++) add(((i / 2) % 2 == 0) ? 30'd0 : fb(0), '0, 1, -1, '0);
      add(fb(0), '0, 6, -1, '0);
      add('0, '0, 10, -1, '0);
      run_tbl("bounce");
      add({30{1'b1}}, '0, D + 5, D + 2, {30{1'b1}});
      add('0, '0, 10, -1, '0);
      run_tbl("simultaneous");
      add(fb(9), '0, D + 3, D + 2, fb(9));
      run_tbl("pulse_live");
      rst_n = 1'b0;
      #1;
      check("async_clear", '0);
      add('0, '0, 2, -1, '0);
      run_tbl("held_reset");
      rst_n = 1'b1;
      add('0, '0, 4, -1, '0);
      run_tbl("post_clear_idle");
      add(fb(7), '0, 5, -1, '0);
      run_tbl("mid_pre");
      rst_n = 1'b0;
      #1;
      check("mid_reset", '0);
      add(fb(7), '0, 2, -1, '0);
      run_tbl("mid_hold");
      rst_n = 1'b1;
      add(fb(7), '0, 12, D + 2, fb(7));
      add('0, '0, 10, -1, '0);
      run_tbl("after_reset");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
